// File: rtl/mulu_m6q6_seq.sv
// rtl/mulu_m6q6_seq.sv - multi-cycle unsigned 6x6 multiplier built on one shared 3x3 core
//
// mulu_m3q3: combinational unsigned 3x3 multiplier core.
//   a_i [2:0]  multiplicand chunk
//   b_i [2:0]  multiplier chunk
//   p_o [5:0]  product a_i*b_i
//
// mulu_m6q6_seq: four-step sequential 6x6 multiplier. Operands are accepted and
// the 12-bit product is returned through valid/ready handshakes.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands x,y present
//   in_ready   block can accept operands this cycle
//   x, y       unsigned operands [WIDTH-1:0]
//   out_valid  p holds a completed product
//   out_ready  consumer takes p this cycle
//   p          unsigned product [2*WIDTH-1:0]
//   busy       high while the partial-product steps run

module mulu_m3q3 (
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  output logic [5:0] p_o
);
  assign p_o = {3'b000, a_i} * {3'b000, b_i};
endmodule

module mulu_m6q6_seq #(
  parameter int CHUNK = 3,  // must match the 3x3 core
  parameter int WIDTH = 6   // must equal 2*CHUNK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           step_q, step_d;
  logic [WIDTH-1:0]     x_q, x_d, y_q, y_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;

  logic [CHUNK-1:0]     cx, cy;
  logic [2*CHUNK-1:0]   core_p;
  logic [2*WIDTH-1:0]   core_ext, addend;
  logic                 accept;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL);
  assign p         = acc_q;

  mulu_m3q3 u_core (
    .a_i (cx),
    .b_i (cy),
    .p_o (core_p)
  );

  // step[0] picks the x half and step[1] the y half, giving the order
  // xL*yL, xH*yL, xL*yH, xH*yH. Core inputs rest at 0 outside MUL.
  always_comb begin
    cx = '0;
    cy = '0;
    if (state_q == S_MUL) begin
      cx = step_q[0] ? x_q[WIDTH-1:CHUNK] : x_q[CHUNK-1:0];
      cy = step_q[1] ? y_q[WIDTH-1:CHUNK] : y_q[CHUNK-1:0];
    end
  end

  assign core_ext = {{(2*WIDTH-2*CHUNK){1'b0}}, core_p};

  always_comb begin
    addend = core_ext;
    case (step_q)
      2'd0:    addend = core_ext;
      2'd1,
      2'd2:    addend = core_ext << CHUNK;
      default: addend = core_ext << (2*CHUNK);
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d     = x;
          y_d     = y;
          step_d  = 2'd0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        // Step 0 loads rather than adds, so the accumulator starts from zero
        // while p still holds the previous product until MUL begins.
        acc_d  = ((step_q == 2'd0) ? '0 : acc_q) + addend;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            x_d     = x;
            y_d     = y;
            step_d  = 2'd0;
            state_d = S_MUL;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: tb/tb_mulu_m6q6_seq.sv
// tb/tb_mulu_m6q6_seq.sv - scoreboard bench for mulu_m6q6_seq
module tb_mulu_m6q6_seq;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  x;
  logic [5:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] p;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  int exp_q[$];
  int lat_q[$];
  int hs_log[$];

  mulu_m6q6_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks
  // latency, hold-while-stalled and the single-cycle handshake.
  logic mon_prev_valid = 1'b0;
  logic mon_hs_prev    = 1'b0;
  logic mon_stall_prev = 1'b0;
  int   mon_held_p     = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_valid = 1'b0;
      mon_hs_prev    = 1'b0;
      mon_stall_prev = 1'b0;
    end else begin
      if (mon_hs_prev) chk("valid_drops_after_handshake", int'(out_valid), 0);
      if (mon_stall_prev) begin
        chk("valid_held_in_stall", int'(out_valid), 1);
        chk("p_held_in_stall", int'(p), mon_held_p);
      end
      if (out_valid && !mon_prev_valid) begin
        if (lat_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("latency", cyc - lat_q.pop_front(), 4);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_product", int'(p), -1);
        else chk("product", int'(p), exp_q.pop_front());
        hs_log.push_back(cyc);
      end
      mon_hs_prev    = out_valid && out_ready;
      mon_stall_prev = out_valid && !out_ready;
      mon_held_p     = int'(p);
      mon_prev_valid = out_valid;
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [5:0] a, input logic [5:0] b, input int e, input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    x = a;
    y = b;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        lat_q.push_back(cyc + 1);
        break;
      end
      t++;
      if (t > 200) begin
        chk("accept_timeout", t, 0);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = 6'($urandom);
    y = 6'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    y        = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1. reset state
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_p", int'(p), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;

    // 2. basic product
    rdy_mode = 1;
    send(6'd5, 6'd7, 35, 0);
    @(negedge clk);
    chk("busy_during_mul", int'(busy), 1);
    @(posedge clk);
    #1;
    drain();

    // 3. max and zero
    send(6'd63, 6'd63, 3969, 1);
    drain();
    send(6'd0, 6'd63, 0, 1);
    drain();

    // 4. stalled consumer
    rdy_mode = 0;
    send(6'd42, 6'd27, 1134, 1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_out_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_in_ready_low", int'(in_ready), 0);
      chk("stall_p_value", int'(p), 1134);
    end
    rdy_mode = 1;
    @(posedge clk);
    #1;
    drain();

    // 5. back-to-back
    hs_log.delete();
    send(6'd3, 6'd4, 12, 0);
    send(6'd6, 6'd9, 54, 0);
    send(6'd63, 6'd1, 63, 0);
    drain();
    chk("b2b_handshakes", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      chk("b2b_spacing_1", hs_log[1] - hs_log[0], 5);
      chk("b2b_spacing_2", hs_log[2] - hs_log[1], 5);
    end

    // 6. reset during step 2
    send(6'd9, 6'd9, 81, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    chk("midreset_p", int'(p), 0);
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_valid_after_reset", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    send(6'd2, 6'd3, 6, 0);
    drain();

    // 7. exhaustive with random gaps and back-pressure
    rdy_mode = 2;
    for (int xi = 0; xi < 64; xi++) begin
      for (int yi = 0; yi < 64; yi++) begin
        send(6'(xi), 6'(yi), xi * yi, ($urandom_range(0, 3) == 0) ? 1 : 0);
      end
    end
    rdy_mode = 1;
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
